// File: rtl/lcd_sequencer.sv
// HD44780 character LCD sequencer: power-up wait, fixed init ROM, then one
// instruction/data byte per valid/ready handshake with counter-timed RS/EN/DB
// strobing and execution waits. The LCD busy flag is never read.
module lcd_sequencer #(
  parameter int unsigned T_POWERUP   = 375000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN_HIGH   = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1000,
  parameter int unsigned T_EXEC_LONG = 40000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_vld,
  output logic       o_req_rdy,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_init_done,
  output logic       o_busy,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  // Counter must hold the largest timing parameter.
  localparam int unsigned Max0 = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned Max1 = (T_EXEC > T_EN_HIGH) ? T_EXEC : T_EN_HIGH;
  localparam int unsigned Max2 = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned Max3 = (Max0 > Max1) ? Max0 : Max1;
  localparam int unsigned MaxT = (Max3 > Max2) ? Max3 : Max2;
  localparam int unsigned CntW = $clog2(MaxT) + 1;

  typedef enum logic [2:0] {
    StPwrup,
    StLoad,
    StSetup,
    StEn,
    StHold,
    StExec,
    StIdle
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [7:0]      rom_byte;
  logic            exec_long;
  logic [CntW-1:0] exec_load;

  // Init ROM: 8-bit/2-line, display on, clear, entry mode increment.
  always_comb begin
    rom_byte = 8'h38;
    unique case (idx_q)
      2'd0: rom_byte = 8'h38;
      2'd1: rom_byte = 8'h0C;
      2'd2: rom_byte = 8'h01;
      2'd3: rom_byte = 8'h06;
      default: rom_byte = 8'h38;
    endcase
  end

  // Clear display / return home (0x01..0x03) need the long execution wait.
  assign exec_long = ~o_lcd_rs & (o_lcd_data[7:2] == 6'd0) & (o_lcd_data[1:0] != 2'd0);
  assign exec_load = exec_long ? CntW'(T_EXEC_LONG - 1) : CntW'(T_EXEC - 1);

  assign o_req_rdy = (state_q == StIdle);
  assign o_busy    = ~o_req_rdy;
  assign o_lcd_rw  = 1'b0;

  // Sequencer FSM with down-counter and registered LCD pin outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StPwrup;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      o_init_done <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_on    <= 1'b0;
    end else begin
      o_lcd_on <= 1'b1;
      unique case (state_q)
        StPwrup: begin
          // o_lcd_on low marks the first cycle out of reset; the counter is armed there
          // so that the whole power-up wait spans exactly T_POWERUP cycles.
          if (!o_lcd_on) begin
            if (T_POWERUP <= 1) begin
              state_q <= StLoad;
            end else begin
              cnt_q <= CntW'(T_POWERUP - 2);
            end
          end else if (cnt_q == '0) begin
            state_q <= StLoad;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StLoad: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= rom_byte;
          cnt_q      <= CntW'(T_SETUP - 1);
          state_q    <= StSetup;
        end
        StSetup: begin
          if (cnt_q == '0) begin
            o_lcd_en <= 1'b1;
            cnt_q    <= CntW'(T_EN_HIGH - 1);
            state_q  <= StEn;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StEn: begin
          if (cnt_q == '0) begin
            o_lcd_en <= 1'b0;
            cnt_q    <= CntW'(T_HOLD - 1);
            state_q  <= StHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            cnt_q   <= exec_load;
            state_q <= StExec;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            if (o_init_done) begin
              state_q <= StIdle;
            end else if (idx_q != 2'd3) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StLoad;
            end else begin
              o_init_done <= 1'b1;
              state_q     <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StIdle: begin
          if (i_req_vld) begin
            o_lcd_rs   <= i_req_rs;
            o_lcd_data <= i_req_data;
            cnt_q      <= CntW'(T_SETUP - 1);
            state_q    <= StSetup;
          end
        end
        default: state_q <= StPwrup;
      endcase
    end
  end

  // Pin-level invariants.
  a_en_only_in_en: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_lcd_en == (state_q == StEn));
  a_bus_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == StEn || state_q == StHold) |-> $stable({o_lcd_rs, o_lcd_data}));
  a_rw_low: assert property (@(posedge i_clk) o_lcd_rw == 1'b0);

endmodule
